// File: rtl/sram_arbiter.sv
// Purpose : shares one single-port SRAM between a read port and a buffered write port.
// Latency : mem_* one cycle after the grant; rd_valid READ_LATENCY+1 cycles after rd_ack.
// Backpressure: reads are accepted only when rd_ack=1; writes are accepted only when wr_ready=1 (buffer not full).
//
// Ports:
//   clk, reset                     single clock, synchronous active-high reset
//   rd_req/rd_addr -> rd_ack       read request, combinational grant
//   rd_valid/rd_data               returned read word (rd_data holds between pulses)
//   wr_req/wr_addr/wr_data         push into write buffer when wr_ready
//   mem_write_enable/mem_addr/mem_data_in   registered SRAM controls
//   mem_data_out                   SRAM read data, valid READ_LATENCY cycles after mem_* drive
module sram_arbiter #(
  parameter int FIFO_DEPTH      = 4,
  parameter int READ_LATENCY    = 4,
  parameter int MAX_READ_STREAK = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [19:0] rd_addr,
  output logic        rd_ack,
  output logic        rd_valid,
  output logic [16:0] rd_data,
  input  logic        wr_req,
  input  logic [19:0] wr_addr,
  input  logic [16:0] wr_data,
  output logic        wr_ready,
  output logic        mem_write_enable,
  output logic [19:0] mem_addr,
  output logic [16:0] mem_data_in,
  input  logic [16:0] mem_data_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(MAX_READ_STREAK + 1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW:0]   CNT_ONE   = (PW + 1)'(1);
  localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);
  localparam logic [SW-1:0] STRK_ONE  = SW'(1);
  localparam logic [SW-1:0] STRK_MAX  = SW'(MAX_READ_STREAK);

  typedef enum logic [1:0] {OP_IDLE, OP_READ, OP_WRITE, OP_TURN} op_e;

  // Write buffer storage: {addr, data}
  logic [36:0]   r_buf [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;

  logic [SW-1:0]       r_streak;
  op_e                 r_op;
  op_e                 w_op;
  logic [READ_LATENCY:0] r_rd_pipe;
  logic [16:0]         r_rd_data;
  logic                r_mem_we;
  logic [19:0]         r_mem_addr;
  logic [16:0]         r_mem_din;

  logic        w_empty;
  logic        w_full;
  logic        w_streak_max;
  logic        w_push;
  logic        w_pop;
  logic [36:0] w_head;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == DEPTH_C);
  assign w_streak_max = (r_streak >= STRK_MAX);
  assign w_head       = r_buf[r_rd_ptr];

  // Grant decision. r_op remembers last cycle's operation so a READ is
  // never issued directly after a WRITE (bus turnaround).
  always_comb begin
    w_op = OP_IDLE;
    if (reset) begin
      w_op = OP_IDLE;
    end else if (!w_empty && (!rd_req || w_full || w_streak_max)) begin
      w_op = OP_WRITE;
    end else if (r_op == OP_WRITE) begin
      w_op = OP_TURN;
    end else if (rd_req) begin
      w_op = OP_READ;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_op <= OP_IDLE;
    else       r_op <= w_op;
  end

  assign rd_ack   = (w_op == OP_READ);
  // Full blocks a push even when the same cycle pops.
  assign wr_ready = !w_full;
  assign w_push   = wr_req && !w_full && !reset;
  assign w_pop    = (w_op == OP_WRITE);

  always_ff @(posedge clk) begin
    if (w_push) r_buf[r_wr_ptr] <= {wr_addr, wr_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Read streak only matters while a write waits; it saturates so the
  // forced-write condition stays asserted until the write is granted.
  always_ff @(posedge clk) begin
    if (reset || w_empty || w_op == OP_WRITE) begin
      r_streak <= '0;
    end else if (w_op == OP_READ && !w_streak_max) begin
      r_streak <= r_streak + STRK_ONE;
    end
  end

  // SRAM controls; TURN/IDLE keep the address and just deassert write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
    end else begin
      case (w_op)
        OP_WRITE: begin
          r_mem_we   <= 1'b1;
          r_mem_addr <= w_head[36:17];
          r_mem_din  <= w_head[16:0];
        end
        OP_READ: begin
          r_mem_we   <= 1'b0;
          r_mem_addr <= rd_addr;
        end
        default: r_mem_we <= 1'b0;
      endcase
    end
  end

  assign mem_write_enable = r_mem_we;
  assign mem_addr         = r_mem_addr;
  assign mem_data_in      = r_mem_din;

  // Only acked reads enter the pipe, so dummy reads never produce rd_valid.
  always_ff @(posedge clk) begin
    if (reset) r_rd_pipe <= '0;
    else       r_rd_pipe <= {r_rd_pipe[READ_LATENCY-1:0], rd_ack};
  end

  assign rd_valid = r_rd_pipe[READ_LATENCY];

  // SRAM data is only valid during the rd_valid cycle, so it is passed
  // through then and captured for holding afterwards.
  always_ff @(posedge clk) begin
    if (reset)         r_rd_data <= '0;
    else if (rd_valid) r_rd_data <= mem_data_out;
  end

  assign rd_data = rd_valid ? mem_data_out : r_rd_data;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
  localparam int FD = 4;
  localparam int RL = 4;
  localparam int MS = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req = 1'b0;
  logic [19:0] rd_addr = '0;
  logic        rd_ack;
  logic        rd_valid;
  logic [16:0] rd_data;
  logic        wr_req = 1'b0;
  logic [19:0] wr_addr = '0;
  logic [16:0] wr_data = '0;
  logic        wr_ready;
  logic        mem_write_enable;
  logic [19:0] mem_addr;
  logic [16:0] mem_data_in;
  logic [16:0] mem_data_out = '0;

  always #5 clk = ~clk;

  sram_arbiter #(.FIFO_DEPTH(FD), .READ_LATENCY(RL), .MAX_READ_STREAK(MS)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] init_val(input logic [19:0] a);
    return a[16:0] ^ 17'h0A5C3;
  endfunction

  // ---------------- SRAM environment: READ_LATENCY-cycle read data ----------------
  logic [16:0] sram [logic [19:0]];
  logic [16:0] dline [int];
  int e_cyc = 0;

  always @(posedge clk) begin
    #1;
    if (!$isunknown({mem_write_enable, mem_addr})) begin
      if (mem_write_enable) sram[mem_addr] = mem_data_in;
      else dline[e_cyc + RL] = sram.exists(mem_addr) ? sram[mem_addr] : init_val(mem_addr);
    end
    if (dline.exists(e_cyc)) begin
      mem_data_out = dline[e_cyc];
      dline.delete(e_cyc);
    end else begin
      mem_data_out = 17'($urandom);
    end
    e_cyc++;
  end

  // ---------------- Reference model (transaction level) ----------------
  typedef struct packed { logic [19:0] a; logic [16:0] d; } wr_t;
  typedef struct { int due; logic [16:0] d; } pr_t;

  wr_t         wq[$];
  pr_t         pend[$];
  logic [16:0] refmem [logic [19:0]];
  int          streak = 0;
  bit          last_wr = 1'b0;
  logic        m_we = 1'b0;
  logic [19:0] m_addr = '0;
  logic [16:0] m_din = '0;
  logic [16:0] m_rd = '0;
  int          cyc = 0;

  function automatic logic [16:0] ref_val(input logic [19:0] a);
    return refmem.exists(a) ? refmem[a] : init_val(a);
  endfunction

  task automatic step(input bit i_rst, input bit i_rd, input logic [19:0] ra,
                      input bit i_wr, input logic [19:0] wa, input logic [16:0] wd);
    bit  full, empty, do_wr, do_rd, exp_v;
    wr_t e;
    pr_t p;
    @(negedge clk);
    reset = i_rst; rd_req = i_rd; rd_addr = ra;
    wr_req = i_wr; wr_addr = wa; wr_data = wd;
    #1;
    full  = (wq.size() == FD);
    empty = (wq.size() == 0);
    do_wr = !i_rst && !empty && (!i_rd || full || streak >= MS);
    do_rd = !i_rst && !do_wr && i_rd && !last_wr;
    check("rd_ack", 32'(rd_ack), 32'(do_rd));
    check("wr_ready", 32'(wr_ready), 32'(!full));
    check("mem_we", 32'(mem_write_enable), 32'(m_we));
    check("mem_addr", 32'(mem_addr), 32'(m_addr));
    check("mem_din", 32'(mem_data_in), 32'(m_din));
    exp_v = (pend.size() > 0) && (pend[0].due == cyc);
    check("rd_valid", 32'(rd_valid), 32'(exp_v));
    if (exp_v) begin
      check("rd_data", 32'(rd_data), 32'(pend[0].d));
      m_rd = pend[0].d;
      void'(pend.pop_front());
    end else begin
      check("rd_data_hold", 32'(rd_data), 32'(m_rd));
    end
    @(posedge clk);
    if (i_rst) begin
      wq.delete(); pend.delete();
      streak = 0; last_wr = 1'b0;
      m_we = 1'b0; m_addr = '0; m_din = '0; m_rd = '0;
    end else begin
      if (do_wr) begin
        e = wq.pop_front();
        refmem[e.a] = e.d;
        m_we = 1'b1; m_addr = e.a; m_din = e.d;
      end else begin
        m_we = 1'b0;
        if (do_rd) m_addr = ra;
      end
      if (do_rd) begin
        p.due = cyc + RL + 1;
        p.d   = ref_val(ra);
        pend.push_back(p);
      end
      if (empty || do_wr) streak = 0;
      else if (do_rd && streak < MS) streak++;
      if (i_wr && !full) begin
        e.a = wa; e.d = wd;
        wq.push_back(e);
      end
      last_wr = do_wr;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 20'h0, 0, 20'h0, 17'h0);
  endtask

  int rd_pct[4] = '{50, 90, 10, 100};
  int wr_pct[4] = '{50, 30, 80, 60};

  initial begin
    repeat (2) @(posedge clk);
    step(1, 0, 20'h0, 0, 20'h0, 17'h0);
    step(1, 1, 20'h5, 1, 20'h5, 17'h1);   // push during reset is dropped
    idle(2);

    // single read
    step(0, 1, 20'h00010, 0, 20'h0, 17'h0);
    idle(7);

    // two writes, no reads
    step(0, 0, 20'h0, 1, 20'h00001, 17'h0AAAA);
    step(0, 0, 20'h0, 1, 20'h00002, 17'h15555);
    idle(4);

    // read streak limit with one write waiting
    step(0, 1, 20'h00001, 1, 20'h00003, 17'h01234);
    for (int i = 0; i < 14; i++) step(0, 1, 20'(i % 4), 0, 20'h0, 17'h0);
    idle(6);

    // fill the buffer while reads are requested
    for (int i = 0; i < 8; i++) step(0, 1, 20'h00002, 1, 20'(8 + i), 17'(17'h100 + i));
    for (int i = 0; i < 12; i++) step(0, 1, 20'h00009, 0, 20'h0, 17'h0);
    idle(6);

    // write followed by a read request
    step(0, 0, 20'h0, 1, 20'h00004, 17'h00777);
    step(0, 1, 20'h00004, 0, 20'h0, 17'h0);
    step(0, 1, 20'h00004, 0, 20'h0, 17'h0);
    step(0, 1, 20'h00004, 0, 20'h0, 17'h0);
    idle(7);

    // reset two cycles after a read ack
    step(0, 1, 20'h00006, 0, 20'h0, 17'h0);
    idle(1);
    step(1, 0, 20'h0, 0, 20'h0, 17'h0);
    idle(8);

    // randomized phases
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 1000; i++) begin
        step($urandom_range(0, 199) == 0,
             $urandom_range(0, 99) < rd_pct[ph], 20'($urandom_range(0, 15)),
             $urandom_range(0, 99) < wr_pct[ph], 20'($urandom_range(0, 15)),
             17'($urandom));
      end
      idle(8);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
